// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/sequencing controller of the 5-stage pipeline.
package hazard_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StErr     = 2'd2
  } state_e;

  localparam logic [1:0] FWD_NONE     = 2'b00;
  localparam logic [1:0] FWD_WB       = 2'b01;
  localparam logic [1:0] FWD_MEM      = 2'b10;
  localparam logic [1:0] RES_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_sched_pipe_forward_sel.sv
// E-stage operand forwarding select for one source register; the younger M result wins over W.
module forward_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_NONE;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_sched_pipe.sv
// Pipeline stall/flush/forward control with data-memory wait sequencing and timeout.
// Optional performance counters are enabled with the HAZARD_PERF_EN macro.
module hazard_sched_pipe
  import hazard_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic [4:0]       rd_m,
  input  logic [4:0]       rd_w,
  input  logic [1:0]       res_src_e,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  input  logic             pc_src_e,
  input  logic             mem_access_m,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        mem_err_q, mem_err_d;
  logic        mem_stall;
  logic        load_use;
  logic [1:0]  fwd_a, fwd_b;

  forward_sel u_fwd_a (
    .rs          (rs1_e),
    .rd_m        (rd_m),
    .rd_w        (rd_w),
    .reg_write_m (reg_write_m),
    .reg_write_w (reg_write_w),
    .sel         (fwd_a)
  );

  forward_sel u_fwd_b (
    .rs          (rs2_e),
    .rd_m        (rd_m),
    .rd_w        (rd_w),
    .reg_write_m (reg_write_m),
    .reg_write_w (reg_write_w),
    .sel         (fwd_b)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StRun;
      wait_cnt_q <= 16'd0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    unique case (state_q)
      StRun: begin
        if (mem_access_m && !mem_ready) begin
          state_d    = StMemWait;
          wait_cnt_d = 16'd1;
        end
      end
      StMemWait: begin
        if (mem_ready) begin
          state_d    = StRun;
          wait_cnt_d = 16'd0;
        end else if (wait_cnt_q == TimeoutCnt) begin
          state_d   = StErr;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      StErr: mem_err_d = 1'b1;
      default: begin
        state_d   = StErr;
        mem_err_d = 1'b1;
      end
    endcase
  end

  assign load_use = (res_src_e == RES_SRC_LOAD) && (rd_e != 5'd0) &&
                    ((rd_e == rs1_d) || (rd_e == rs2_d));

  always_comb begin
    mem_req     = 1'b0;
    mem_stall   = 1'b0;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_w     = 1'b0;
    forward_a_e = FWD_NONE;
    forward_b_e = FWD_NONE;

    unique case (state_q)
      StRun: begin
        mem_req   = mem_access_m;
        mem_stall = mem_access_m && !mem_ready;
      end
      StMemWait: begin
        mem_req   = mem_access_m;
        mem_stall = !mem_ready;
      end
      default: mem_stall = 1'b1;
    endcase

    if (!rst) begin
      // Outputs must reflect reset immediately, ahead of any clock edge.
      mem_req = 1'b0;
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      forward_a_e = fwd_a;
      forward_b_e = fwd_b;
      if (mem_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (pc_src_e) begin
        // A taken branch squashes D, so any load-use against it is moot.
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_e && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_sched_pipe.sv
// Directed, table-driven bench for hazard_sched_pipe (TIMEOUT_CYCLES=4).
module tb_hazard_sched_pipe;
  import hazard_pkg::*;

  localparam int unsigned CntW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [4:0]      rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0]      res_src_e;
  logic            reg_write_m, reg_write_w, pc_src_e, mem_access_m, mem_ready;
  logic            mem_req, stall_f, stall_d, stall_e, stall_m;
  logic            flush_d, flush_e, flush_w, mem_err;
  logic [1:0]      forward_a_e, forward_b_e;
  logic [CntW-1:0] stall_count, flush_count;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_stall_cnt = 0;
  int exp_flush_cnt = 0;

  always #5 clk = ~clk;

  hazard_sched_pipe #(
    .TIMEOUT_CYCLES (4),
    .CNT_W          (CntW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .rs1_e        (rs1_e),
    .rs2_e        (rs2_e),
    .rd_e         (rd_e),
    .rd_m         (rd_m),
    .rd_w         (rd_w),
    .res_src_e    (res_src_e),
    .reg_write_m  (reg_write_m),
    .reg_write_w  (reg_write_w),
    .pc_src_e     (pc_src_e),
    .mem_access_m (mem_access_m),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .stall_e      (stall_e),
    .stall_m      (stall_m),
    .flush_d      (flush_d),
    .flush_e      (flush_e),
    .flush_w      (flush_w),
    .forward_a_e  (forward_a_e),
    .forward_b_e  (forward_b_e),
    .mem_err      (mem_err),
    .stall_count  (stall_count),
    .flush_count  (flush_count)
  );

  typedef struct {
    string      name;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0] res_src_e;
    logic       rw_m, rw_w, pc_src;
    logic       x_sf, x_sd, x_fd, x_fe;
    logic [1:0] x_fa, x_fb;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic idle();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    res_src_e = 0; reg_write_m = 0; reg_write_w = 0; pc_src_e = 0;
    mem_access_m = 0; mem_ready = 0;
  endtask

  // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_req}
  function automatic logic [7:0] ctl();
    return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_req};
  endfunction

  task automatic chk_cnt(input string name);
`ifdef HAZARD_PERF_EN
    chk({name, "_stall_cnt"}, stall_count, exp_stall_cnt);
    chk({name, "_flush_cnt"}, flush_count, exp_flush_cnt);
`else
    chk({name, "_stall_cnt"}, stall_count, 0);
    chk({name, "_flush_cnt"}, flush_count, 0);
`endif
  endtask

  initial begin
    //            name        rs1d rs2d rs1e rs2e rde rdm rdw res   rwm rww pc  sf sd fd fe fa     fb
    vecs[0]  = '{"idle",      0,   0,   0,   0,   0,  0,  0,  2'b00, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00};
    vecs[1]  = '{"lu_rs1",    5,   0,   0,   0,   5,  0,  0,  2'b01, 0, 0, 0,  1, 1, 0, 1, 2'b00, 2'b00};
    vecs[2]  = '{"lu_rs2",    1,   9,   0,   0,   9,  0,  0,  2'b01, 0, 0, 0,  1, 1, 0, 1, 2'b00, 2'b00};
    vecs[3]  = '{"lu_x0",     0,   0,   0,   0,   0,  0,  0,  2'b01, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00};
    vecs[4]  = '{"alu_match", 5,   0,   0,   0,   5,  0,  0,  2'b00, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00};
    vecs[5]  = '{"pc4_match", 5,   0,   0,   0,   5,  0,  0,  2'b10, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00};
    vecs[6]  = '{"br_vs_lu",  5,   0,   0,   0,   5,  0,  0,  2'b01, 0, 0, 1,  0, 0, 1, 1, 2'b00, 2'b00};
    vecs[7]  = '{"branch",    0,   0,   0,   0,   0,  0,  0,  2'b00, 0, 0, 1,  0, 0, 1, 1, 2'b00, 2'b00};
    vecs[8]  = '{"fwd_m_pri", 0,   0,   7,   0,   0,  7,  7,  2'b00, 1, 1, 0,  0, 0, 0, 0, 2'b10, 2'b00};
    vecs[9]  = '{"fwd_w",     0,   0,   7,   0,   0,  0,  7,  2'b00, 1, 1, 0,  0, 0, 0, 0, 2'b01, 2'b00};
    vecs[10] = '{"fwd_x0",    0,   0,   0,   0,   0,  0,  0,  2'b00, 1, 1, 0,  0, 0, 0, 0, 2'b00, 2'b00};
    vecs[11] = '{"fwd_nowrm", 0,   0,   0,   3,   0,  3,  3,  2'b00, 0, 1, 0,  0, 0, 0, 0, 2'b00, 2'b01};
    vecs[12] = '{"fwd_indep", 0,   0,   4,   6,   0,  4,  6,  2'b00, 1, 1, 0,  0, 0, 0, 0, 2'b10, 2'b01};

    idle();
    rst = 1'b0;
    #1;
    chk("rst_ctl", ctl(), 8'b0000_1100);
    chk("rst_err", mem_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_ctl", ctl(), 8'b0);
    chk_cnt("post_rst");

    // Each vector is held across exactly one rising edge.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      rs1_d = vecs[i].rs1_d; rs2_d = vecs[i].rs2_d; rs1_e = vecs[i].rs1_e;
      rs2_e = vecs[i].rs2_e; rd_e = vecs[i].rd_e; rd_m = vecs[i].rd_m; rd_w = vecs[i].rd_w;
      res_src_e = vecs[i].res_src_e; reg_write_m = vecs[i].rw_m;
      reg_write_w = vecs[i].rw_w; pc_src_e = vecs[i].pc_src;
      #1;
      chk({vecs[i].name, "_ctl"}, ctl(),
          {vecs[i].x_sf, vecs[i].x_sd, 2'b00, vecs[i].x_fd, vecs[i].x_fe, 2'b00});
      chk({vecs[i].name, "_fa"}, forward_a_e, vecs[i].x_fa);
      chk({vecs[i].name, "_fb"}, forward_b_e, vecs[i].x_fb);
      if (vecs[i].x_sf) exp_stall_cnt++;
      if (vecs[i].x_fe) exp_flush_cnt++;
    end

    // Load-use bubble then cleared E: exactly one stall cycle.
    @(negedge clk);
    idle();
    #1;
    chk("lu_release_ctl", ctl(), 8'b0);
    chk_cnt("after_vecs");

    // Memory access with three wait cycles; a branch in the middle must be ignored.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      idle();
      mem_access_m = 1'b1;
      mem_ready    = (c == 3);
      pc_src_e     = (c == 1);
      #1;
      if (c < 3) begin
        chk($sformatf("mw_stall_c%0d", c), ctl(), 8'b1111_0011);
        exp_stall_cnt++;
      end else begin
        chk("mw_done", ctl(), 8'b0000_0001);
      end
    end
    @(negedge clk);
    idle();
    #1;
    chk("mw_after", ctl(), 8'b0);
    chk("mw_no_err", mem_err, 0);
    chk_cnt("after_mw");
    // Zero-wait access back in RUN.
    @(negedge clk);
    mem_access_m = 1'b1;
    mem_ready    = 1'b1;
    #1;
    chk("zero_wait", ctl(), 8'b0000_0001);

    // Timeout: five stalled cycles, then ERR.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mem_access_m = 1'b1;
      mem_ready    = 1'b0;
      #1;
      chk($sformatf("to_stall_c%0d", c), ctl(), 8'b1111_0011);
      chk($sformatf("to_err_c%0d", c), mem_err, 0);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_access_m = 1'b1;
      mem_ready    = (c != 0);
      #1;
      chk($sformatf("err_ctl_c%0d", c), ctl(), 8'b1111_0010);
      chk($sformatf("err_flag_c%0d", c), mem_err, 1);
    end

    // Leave ERR, enter MEM_WAIT, then assert reset between clock edges.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle();
    mem_access_m = 1'b1;
    repeat (2) @(negedge clk);
    rs1_e = 7; rd_m = 7; reg_write_m = 1'b1;
    #1;
    chk("mid_wait_stall", ctl(), 8'b1111_0011);
    chk("mid_wait_fwd", forward_a_e, FWD_MEM);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_ctl", ctl(), 8'b0000_1100);
    chk("async_rst_fwd", forward_a_e, FWD_NONE);
    chk("async_rst_err", mem_err, 0);
    @(negedge clk);
    idle();
    rst = 1'b1;
    #1;
    exp_stall_cnt = 0;
    exp_flush_cnt = 0;
    chk("rel_ctl", ctl(), 8'b0);
    chk("rel_err", mem_err, 0);
    chk_cnt("rel");
    @(negedge clk);
    mem_access_m = 1'b1;
    mem_ready    = 1'b1;
    #1;
    chk("rel_zero_wait", ctl(), 8'b0000_0001);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_sched_pipe.md
Name: hazard_sched_pipe

Overview:
Hazard and pipeline-sequencing controller for the 5-stage RISC-V pipeline (F/D/E/M/W).
- Generates per-stage stall/flush enables for the pipeline registers and the E-stage forwarding selects.
- Sequences the data-memory handshake, including a wait-timeout error.
- Consumes control fields already decoded and piped per stage by the decoder.

Parameters:
TIMEOUT_CYCLES, 255, max consecutive cycles in MEM_WAIT before error; legal range 1..65535.
CNT_W, 32, width of performance counters (used only with optional feature).

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous, active-low reset
rs1_d  input  5  D-stage source reg 1
rs2_d  input  5  D-stage source reg 2
rs1_e  input  5  E-stage source reg 1
rs2_e  input  5  E-stage source reg 2
rd_e  input  5  E-stage destination
rd_m  input  5  M-stage destination
rd_w  input  5  W-stage destination
res_src_e  input  2  E-stage result select; 2'b01 = load
reg_write_m  input  1  M-stage writes register
reg_write_w  input  1  W-stage writes register
pc_src_e  input  1  taken branch or jump resolved in E
mem_access_m  input  1  M-stage instr is lw/sw
mem_ready  input  1  data memory completes access this cycle
mem_req  output  1  data memory request
stall_f  output  1  hold PC
stall_d  output  1  hold F/D register
stall_e  output  1  hold D/E register
stall_m  output  1  hold E/M register
flush_d  output  1  clear F/D register
flush_e  output  1  clear D/E register
flush_w  output  1  clear M/W register (bubble)
forward_a_e  output  2  ALU src A select: 00 regfile, 01 W result, 10 M ALU result
forward_b_e  output  2  same encoding, src B
mem_err  output  1  sticky timeout error
stall_count  output  CNT_W  cycles with stall_f=1
flush_count  output  CNT_W  cycles with flush_e=1

Behaviour:
FSM states:
- RUN, MEM_WAIT, ERR. Registered state, 16-bit wait_cnt, mem_err. All outputs are combinational from state and inputs.

Reset (rst=0, async):
- state=RUN, wait_cnt=0, mem_err=0, counters=0.
- While rst=0: flush_d=flush_e=1; all stalls=0, flush_w=0, mem_req=0, forwards=00.

mem_req:
- mem_req = mem_access_m when state is RUN or MEM_WAIT; 0 in ERR.
- A transfer completes in a cycle with mem_req=1 and mem_ready=1.

RUN:
- mem_req=1 and mem_ready=0: mem_stall=1; next state MEM_WAIT; wait_cnt<=1.
- mem_ready=1 in the same cycle: zero-wait access; no stall.

MEM_WAIT:
- mem_ready=1: mem_stall=0 in that cycle; next state RUN; wait_cnt<=0.
- Otherwise, if wait_cnt==TIMEOUT_CYCLES: next state ERR and mem_err<=1. Else wait_cnt++.

ERR:
- Terminal until reset.
- stall_f/d/e/m=1, flush_w=1, mem_req=0, mem_err=1.

mem_stall=1:
- stall_f=stall_d=stall_e=stall_m=1 and flush_w=1.
- pc_src_e and load-use are ignored; E is frozen and is re-evaluated after release.

Load-use, when not mem_stall and pc_src_e=0:
- Condition: res_src_e==2'b01, rd_e!=0, and rd_e equals rs1_d or rs2_d.
- Response: stall_f=stall_d=1, flush_e=1. Exactly one bubble per occurrence.

Control hazard, when not mem_stall:
- pc_src_e=1 gives flush_d=flush_e=1, stall_f=stall_d=0.
- Branch beats load-use in the same cycle, because the D instruction is squashed.

Forwarding, per source independently:
- 10 if reg_write_m, rd_m!=0 and rd_m==rsX_e.
- Else 01 if reg_write_w, rd_w!=0 and rd_w==rsX_e.
- Else 00.
- M wins over W. x0 never forwards. Forwarding is not gated by stalls.

Optional Feature:
HAZARD_PERF_EN
- Defined: stall_count and flush_count increment on each cycle with stall_f=1 (resp. flush_e=1), rst high. They saturate at all-ones and do not wrap.
- Undefined: both ports are tied to 0 and no counter flops are inferred. The ports are still present.

Decomposition:
Package hazard_pkg:
- State encoding: RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2.
- FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- RES_SRC_LOAD=2'b01.

Sub-module forward_sel:
- Combinational; inputs rs, rd_m, rd_w, reg_write_m, reg_write_w; output 2-bit select.
- Instantiated twice, for A and B.

Test Plan:
1. Load-use: res_src_e=01, rd_e=5, rs1_d=5, all else 0 -> one cycle of stall_f=stall_d=flush_e=1, then all 0.
2. Branch versus load-use: pc_src_e=1 plus the case-1 condition -> flush_d=flush_e=1, stall_f=0.
3. Forward priority: rd_m=rd_w=7, both write, rs1_e=7 -> forward_a_e=10. rd_m=0 -> 01. rs1_e=0 -> 00.
4. Memory wait: mem_access_m=1, mem_ready low 3 cycles then high -> stall_m=flush_w=1 for exactly 3 cycles; state back to RUN; mem_req high 4 cycles.
5. Timeout: TIMEOUT_CYCLES=4, mem_ready held 0 -> mem_err rises after the 5th stalled cycle; all stalls=1; mem_req=0; stays in ERR.
6. Reset mid-wait: rst low asynchronously in MEM_WAIT -> outputs go to reset values immediately (not at the next edge); after release, state=RUN, mem_err=0, counters=0 (with HAZARD_PERF_EN).
